subleq_core: RTL and testbench
==============================

SUBLEQ_CORE -- requirements
Module: subleq_core

Interface
REQ-001 Parameter DATA_W, default 64, memory word and arithmetic width; DATA_W SHALL be >= 3*ADDR_W.
REQ-002 Parameter ADDR_W, default 13, word-address width and IP width.
REQ-003 Parameter HALT_ON_SELF_LOOP, default 1; when 1, a taken branch to its own address halts the core.
REQ-004 iClock  in  1  single clock, all state on rising edge.
REQ-005 iReset_n  in  1  asynchronous active-low reset.
REQ-006 iStart  in  1  start pulse, sampled only in IDLE or HALT.
REQ-007 iStartIP  in  ADDR_W  IP loaded on accepted iStart.
REQ-008 oMemReq  out  1  memory request, held until acknowledged.
REQ-009 oMemWe  out  1  1 = write, 0 = read; valid while oMemReq.
REQ-010 oMemAddr  out  ADDR_W  word address; valid while oMemReq.
REQ-011 oMemWrData  out  DATA_W  write data; valid while oMemReq && oMemWe.
REQ-012 iMemAck  in  1  completes the current request in the same cycle.
REQ-013 iMemRdData  in  DATA_W  read data, valid in the cycle iMemAck is high on a read.
REQ-014 oIP  out  ADDR_W  current instruction pointer.
REQ-015 oBusy  out  1  high in FETCH, READ_A, READ_B and WRITE.
REQ-016 oHalted  out  1  high in HALT.
REQ-017 oRetired  out  32  count of completed instructions, wraps modulo 2^32.

Function
REQ-018 States SHALL be IDLE, FETCH, READ_A, READ_B, WRITE and HALT, held in a registered state variable.
REQ-019 Instruction word layout SHALL be: A = word[3*ADDR_W-1:2*ADDR_W], B = word[2*ADDR_W-1:ADDR_W], C = word[ADDR_W-1:0]; bits above 3*ADDR_W SHALL be ignored.
REQ-020 IDLE/HALT with iStart=1 -> oIP <= iStartIP, oRetired unchanged, next state FETCH; iStart in any other state SHALL be ignored.
REQ-021 oMemReq SHALL be 1 in every state in which oBusy is 1, and 0 in IDLE and HALT.
REQ-022 Addressing: FETCH reads oIP; READ_A reads A; READ_B reads B; WRITE writes B.
REQ-023 A state SHALL advance only on a cycle with oMemReq && iMemAck; without iMemAck, state and all memory outputs SHALL be held stable.
REQ-024 FETCH ack -> latch the instruction word, go to READ_A; READ_A ack -> latch mem[A] into an operand register, go to READ_B; READ_B ack -> latch diff = iMemRdData - mem[A] into a register, go to WRITE.
REQ-025 Subtraction SHALL be DATA_W-bit two's complement, wrapping on overflow; oMemWrData = diff.
REQ-026 leq SHALL be the signed test diff <= 0, i.e. diff[DATA_W-1] is 1 or diff is zero.
REQ-027 WRITE ack -> oRetired increments; oIP <= leq ? C : oIP+1, with oIP+1 wrapping from 2^ADDR_W-1 to 0.
REQ-028 WRITE ack with HALT_ON_SELF_LOOP=1, leq=1 and C == oIP -> next state HALT (oIP = C); otherwise next state FETCH.
REQ-029 With iMemAck tied high, each instruction SHALL take exactly 4 cycles and issue exactly 4 memory transactions.
REQ-030 When A == B, the operand read SHALL still occur; the result is 0, leq=1, and the branch is taken.
REQ-031 An instruction that writes its own instruction word or the next one SHALL see the new value on its next fetch; there is no instruction caching.

Reset
REQ-032 iReset_n low SHALL immediately force state IDLE, oMemReq=0, oMemWe=0, oIP=0, oRetired=0, oBusy=0 and oHalted=0, independent of iClock.
REQ-033 Reset asserted mid-transaction SHALL abandon that transaction; no write SHALL be issued after reset deassertion until a new iStart.
REQ-034 Deassertion SHALL take effect at the first rising edge of iClock after iReset_n rises; the core then stays in IDLE until iStart.

Verification
REQ-035 Memory: word0 = {A=10, B=11, C=5}, mem[10]=3, mem[11]=7; iStart with iStartIP=0, ack tied high -> mem[11]=4, leq=0, oIP=1 after 4 cycles, oRetired=1.
REQ-036 Same setup but mem[11]=3 -> mem[11]=0, branch taken, oIP=5; mem[11]=2 -> mem[11]=all ones (-1), oIP=5.
REQ-037 Word at address 7 = {A=20, B=20, C=7} -> mem[20]=0, oHalted=1, oIP=7, oBusy=0, oRetired incremented by 1; a subsequent iStart with iStartIP=0 resumes execution.
REQ-038 iMemAck randomly low 0-5 cycles per request -> results identical to the tied-high case, and oMemAddr, oMemWe and oMemWrData stable while a request is pending.
REQ-039 iReset_n pulsed low during WRITE -> oMemReq falls in the same cycle, the memory target is unmodified, all outputs are at their reset values, and the core stays in IDLE.
REQ-040 ADDR_W=4: non-branching instruction at address 15 -> oIP wraps to 0; mem[B]=0x8000...0, mem[A]=1 -> result 0x7FFF...F, leq=0.

Source files
------------

// File: rtl/subleq_core.sv
// subleq_core: multi-cycle SUBLEQ processor with a single-port request/ack
// memory interface. Each instruction is fetch, read A, read B, write B;
// the branch to C is taken when the stored difference is <= 0.
module subleq_core #(
    parameter int DATA_W            = 64,
    parameter int ADDR_W            = 13,
    parameter int HALT_ON_SELF_LOOP = 1
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iStartIP,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWrData,
    input  logic              iMemAck,
    input  logic [DATA_W-1:0] iMemRdData,
    output logic [ADDR_W-1:0] oIP,
    output logic              oBusy,
    output logic              oHalted,
    output logic [31:0]       oRetired
);

    localparam int INSTR_W = 3 * ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ_A,
        S_READ_B,
        S_WRITE,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ip_q, ip_d;
    logic [31:0]         retired_q, retired_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   diff_q, diff_d;

    logic [ADDR_W-1:0]   fld_a, fld_b, fld_c;
    logic                leq;
    logic                busy;
    logic                done;

    // Decode of the latched instruction word; bits above 3*ADDR_W never reach instr_q
    assign fld_a = instr_q[3*ADDR_W-1:2*ADDR_W];
    assign fld_b = instr_q[2*ADDR_W-1:ADDR_W];
    assign fld_c = instr_q[ADDR_W-1:0];

    // Signed "<= 0" test on the stored difference
    assign leq  = diff_q[DATA_W-1] | (diff_q == '0);
    assign busy = (state_q == S_FETCH) || (state_q == S_READ_A) ||
                  (state_q == S_READ_B) || (state_q == S_WRITE);
    assign done = busy & iMemAck;

    // Memory port is a pure function of registered state, so it holds while unacked
    always_comb begin
        oMemAddr = ip_q;
        case (state_q)
            S_READ_A: oMemAddr = fld_a;
            S_READ_B: oMemAddr = fld_b;
            S_WRITE:  oMemAddr = fld_b;
            default:  oMemAddr = ip_q;
        endcase
    end

    assign oMemReq    = busy;
    assign oMemWe     = (state_q == S_WRITE);
    assign oMemWrData = diff_q;
    assign oIP        = ip_q;
    assign oBusy      = busy;
    assign oHalted    = (state_q == S_HALT);
    assign oRetired   = retired_q;

    // Next-state and datapath updates; every step waits for a memory ack
    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        retired_d = retired_q;
        instr_d   = instr_q;
        opa_d     = opa_q;
        diff_d    = diff_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (iStart) begin
                    ip_d    = iStartIP;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (done) begin
                    instr_d = iMemRdData[INSTR_W-1:0];
                    state_d = S_READ_A;
                end
            end
            S_READ_A: begin
                if (done) begin
                    opa_d   = iMemRdData;
                    state_d = S_READ_B;
                end
            end
            S_READ_B: begin
                if (done) begin
                    diff_d  = iMemRdData - opa_q;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (done) begin
                    retired_d = retired_q + 32'd1;
                    ip_d      = leq ? fld_c : ip_q + ADDR_W'(1);
                    // A taken branch onto itself can never make progress
                    if ((HALT_ON_SELF_LOOP != 0) && leq && (fld_c == ip_q))
                        state_d = S_HALT;
                    else
                        state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight transaction immediately
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= S_IDLE;
            ip_q      <= '0;
            retired_q <= '0;
            instr_q   <= '0;
            opa_q     <= '0;
            diff_q    <= '0;
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            retired_q <= retired_d;
            instr_q   <= instr_d;
            opa_q     <= opa_d;
            diff_q    <= diff_d;
        end
    end

endmodule

// File: tb/tb_subleq_core.sv
// tb_subleq_core: directed and randomized checks of subleq_core against a
// word-level SUBLEQ reference model; second instance covers ADDR_W=4.
module tb_subleq_core;

    localparam int DW  = 64;
    localparam int AW  = 13;
    localparam int AW4 = 4;
    localparam int K   = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_ip = '0;
    logic          req, we, busy, halted;
    logic [AW-1:0] addr, ip;
    logic [DW-1:0] wdata, rdata;
    logic          ack = 1'b1;
    logic [31:0]   retired;

    logic           start4 = 1'b0;
    logic [AW4-1:0] start_ip4 = '0;
    logic           req4, we4, busy4, halted4;
    logic [AW4-1:0] addr4, ip4;
    logic [DW-1:0]  wdata4, rdata4;
    logic [31:0]    retired4;

    logic [DW-1:0] mem  [0:31];
    logic [DW-1:0] mem4 [0:15];
    logic          ld_en = 1'b0, ld4_en = 1'b0;
    logic [4:0]    ld_addr = '0;
    logic [3:0]    ld4_addr = '0;
    logic [DW-1:0] ld_data = '0, ld4_data = '0;

    logic          rand_ack = 1'b0;
    int            hs_cnt = 0, hs_seen = 0, wait_cnt = 0;
    int            stab_err = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic          p_we = 1'b0;
    logic [DW-1:0] p_wd = '0;

    int n_chk = 0, n_err = 0;

    subleq_core #(.DATA_W(DW), .ADDR_W(AW), .HALT_ON_SELF_LOOP(1)) dut (
        .iClock(clk), .iReset_n(rst_n), .iStart(start), .iStartIP(start_ip),
        .oMemReq(req), .oMemWe(we), .oMemAddr(addr), .oMemWrData(wdata),
        .iMemAck(ack), .iMemRdData(rdata), .oIP(ip), .oBusy(busy),
        .oHalted(halted), .oRetired(retired));

    subleq_core #(.DATA_W(DW), .ADDR_W(AW4), .HALT_ON_SELF_LOOP(1)) dut4 (
        .iClock(clk), .iReset_n(rst_n), .iStart(start4), .iStartIP(start_ip4),
        .oMemReq(req4), .oMemWe(we4), .oMemAddr(addr4), .oMemWrData(wdata4),
        .iMemAck(1'b1), .iMemRdData(rdata4), .oIP(ip4), .oBusy(busy4),
        .oHalted(halted4), .oRetired(retired4));

    // Memories: address aliases modulo the array size, same as the model
    assign rdata  = mem[addr[4:0]];
    assign rdata4 = mem4[addr4];

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (req && ack) begin
            if (we) mem[addr[4:0]] <= wdata;
            hs_cnt <= hs_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (ld4_en) mem4[ld4_addr] <= ld4_data;
        else if (req4 && we4) mem4[addr4] <= wdata4;
    end

    // Ack generator: 0-5 wait cycles per request when rand_ack is set
    always @(negedge clk) begin
        int w;
        w = (hs_cnt != hs_seen) ? int'($urandom_range(0, 5)) : wait_cnt;
        hs_seen  <= hs_cnt;
        ack      <= !rand_ack || (w == 0);
        wait_cnt <= (w > 0) ? w - 1 : 0;
    end

    // Request outputs must not move while a request is pending
    always @(posedge clk) begin
        if (req) begin
            if (pend && (addr !== p_addr || we !== p_we || (we && wdata !== p_wd)))
                stab_err <= stab_err + 1;
            pend   <= !ack;
            p_addr <= addr;
            p_we   <= we;
            p_wd   <= wdata;
        end else begin
            pend <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] enc(input int a, input int b, input int c);
        return {25'b0, 13'(a), 13'(b), 13'(c)};
    endfunction

    function automatic logic [63:0] enc4(input int a, input int b, input int c);
        return {52'b0, 4'(a), 4'(b), 4'(c)};
    endfunction

    task automatic mem_wr(input int a, input logic [63:0] d);
        ld_en = 1'b1; ld_addr = 5'(a); ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic mem4_wr(input int a, input logic [63:0] d);
        ld4_en = 1'b1; ld4_addr = 4'(a); ld4_data = d;
        @(negedge clk);
        ld4_en = 1'b0;
    endtask

    task automatic do_start(input int ipv);
        start = 1'b1; start_ip = 13'(ipv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(halted), 64'd1);
    endtask

    // Reference model: one SUBLEQ instruction on a word array
    logic [63:0] rmem [0:31];
    logic [12:0] rip;
    int          rret;
    bit          rhalt;

    task automatic model_step();
        logic [63:0] w, d;
        logic [12:0] a, b, c;
        w = rmem[rip[4:0]];
        a = w[38:26]; b = w[25:13]; c = w[12:0];
        d = rmem[b[4:0]] - rmem[a[4:0]];
        rmem[b[4:0]] = d;
        rret++;
        if ($signed(d) <= 0) begin
            if (c == rip) rhalt = 1'b1;
            rip = c;
        end else begin
            rip = rip + 13'd1;
        end
    endtask

    initial begin
        logic [63:0] w;
        int cyc;

        // Reset values before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", 64'(req), 0);
        chk("rst_we", 64'(we), 0);
        chk("rst_ip", 64'(ip), 0);
        chk("rst_retired", 64'(retired), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_halted", 64'(halted), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", 64'(busy), 0);

        // No branch: 7-3=4
        mem_wr(0, enc(10, 11, 5));
        mem_wr(1, enc(20, 20, 1));
        mem_wr(5, enc(20, 20, 5));
        mem_wr(10, 3);
        mem_wr(11, 7);
        do_start(0);
        repeat (3) @(negedge clk);
        chk("t1_busy", 64'(busy), 1);
        @(negedge clk);
        chk("t1_mem11", mem[11], 4);
        chk("t1_ip", 64'(ip), 1);
        chk("t1_retired", 64'(retired), 1);
        wait_halt("t1_halt");
        chk("t1_retired2", 64'(retired), 2);

        // Zero result branches
        mem_wr(11, 3);
        do_start(0);
        repeat (4) @(negedge clk);
        chk("t2_mem11", mem[11], 0);
        chk("t2_ip", 64'(ip), 5);
        wait_halt("t2_halt");
        chk("t2_retired", 64'(retired), 4);

        // Negative result branches
        mem_wr(11, 2);
        do_start(0);
        repeat (4) @(negedge clk);
        chk("t3_mem11", mem[11], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_ip", 64'(ip), 5);
        wait_halt("t3_halt");

        // A==B self loop halts after one instruction, then resumes
        mem_wr(20, 5);
        mem_wr(7, enc(20, 20, 7));
        do_start(7);
        repeat (4) @(negedge clk);
        chk("t4_halted", 64'(halted), 1);
        chk("t4_ip", 64'(ip), 7);
        chk("t4_busy", 64'(busy), 0);
        chk("t4_mem20", mem[20], 0);
        chk("t4_retired", 64'(retired), 7);
        mem_wr(11, 7);
        do_start(0);
        chk("t4_resume_busy", 64'(busy), 1);
        wait_halt("t4_resume_halt");
        chk("t4_resume_ip", 64'(ip), 1);
        chk("t4_resume_mem11", mem[11], 4);

        // Random programs, alternating tied-high and random ack
        for (int t = 0; t < 6; t++) begin
            rand_ack = t[0];
            do_reset();
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 3) == 0)
                    w = {$urandom, $urandom};
                else
                    w = {25'($urandom), 13'($urandom_range(0, 31)),
                         13'($urandom_range(0, 31)), 13'($urandom_range(0, 31))};
                rmem[i] = w;
                mem_wr(i, w);
            end
            rip = '0; rret = 0; rhalt = 1'b0;
            for (int s = 0; s < K && !rhalt; s++) model_step();
            do_start(0);
            cyc = 0;
            while (!(retired == 32'(K) || halted) && cyc < 2000) begin
                @(negedge clk);
                cyc++;
            end
            chk("rnd_done", 64'(cyc < 2000), 1);
            chk("rnd_ip", 64'(ip), 64'(rip));
            chk("rnd_retired", 64'(retired), 64'(rret));
            chk("rnd_halted", 64'(halted), 64'(rhalt));
            if (!rand_ack) chk("rnd_cycles", 64'(cyc), 64'(4 * rret));
            for (int i = 0; i < 32; i++)
                if (mem[i] !== rmem[i]) chk($sformatf("rnd_mem%0d", i), mem[i], rmem[i]);
        end
        chk("stable_pending", 64'(stab_err), 0);

        // Reset during WRITE abandons the store
        rand_ack = 1'b0;
        do_reset();
        mem_wr(0, enc(10, 11, 5));
        mem_wr(10, 3);
        mem_wr(11, 7);
        do_start(0);
        repeat (3) @(negedge clk);
        chk("wr_state_we", 64'(we), 1);
        chk("wr_state_addr", 64'(addr), 11);
        #1 rst_n = 1'b0;
        #1;
        chk("wr_rst_req", 64'(req), 0);
        chk("wr_rst_we", 64'(we), 0);
        chk("wr_rst_ip", 64'(ip), 0);
        chk("wr_rst_retired", 64'(retired), 0);
        chk("wr_rst_busy", 64'(busy), 0);
        chk("wr_rst_halted", 64'(halted), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("wr_rst_mem11", mem[11], 7);
        chk("wr_rst_idle_req", 64'(req), 0);
        chk("wr_rst_idle_busy", 64'(busy), 0);

        // ADDR_W=4: IP wrap and signed overflow
        mem4_wr(15, enc4(1, 2, 3));
        mem4_wr(1, 1);
        mem4_wr(2, 64'h8000_0000_0000_0000);
        mem4_wr(0, enc4(4, 4, 0));
        mem4_wr(4, 9);
        start4 = 1'b1; start_ip4 = 4'd15;
        @(negedge clk);
        start4 = 1'b0;
        repeat (4) @(negedge clk);
        chk("a4_ip_wrap", 64'(ip4), 0);
        chk("a4_mem2", mem4[2], 64'h7FFF_FFFF_FFFF_FFFF);
        repeat (4) @(negedge clk);
        chk("a4_halted", 64'(halted4), 1);
        chk("a4_ip", 64'(ip4), 0);
        chk("a4_retired", 64'(retired4), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
